dec38_display: RTL and testbench
================================

# dec38_display

Registered 3-to-8 decoder and display driver: the receiving end of the 8-to-3 priority-encoder path. Accepts an encoded index plus its valid-indicator over a valid/ready handshake, drives the matching one-hot LED bank and the index digit on one seven-segment display, and holds it for a programmable dwell time before accepting the next index. It sits between an encoder/keyboard source and the board LEDs/HEX outputs.

## Interface
- DWELL, 4, cycles each accepted index is shown before the next is accepted; legal range 1..255
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  source has an index to deliver
- in_ready  out  1  block can accept an index
- in_idx  in  3  encoded index 0..7
- in_flag  in  1  encoder indicator; 0 = no input asserted
- led  out  8  one-hot decode of in_idx; bit in_idx set
- hex0  out  7  segments {g,f,e,d,c,b,a}, active-low
- busy  out  1  high while not in IDLE

## Operation
- States: IDLE, SHOW, BLANK (BLANK only with DEC38_BLANK_EN).
- IDLE: in_ready=1, busy=0. Handshake = in_valid & in_ready at a rising edge; captures in_idx/in_flag, loads dwell counter with DWELL-1, goes to SHOW.
- SHOW: in_ready=0, busy=1. led = in_flag ? (8'b1 << idx) : 8'h00. hex0 = digit pattern for idx if flag=1, else 7'h7F (blank).
- Digit patterns, idx 0..7: 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78.
- SHOW, counter==0: go to IDLE (or BLANK with macro); else counter decrements.
- in_valid while not IDLE is ignored; source must hold in_idx/in_flag/in_valid until accepted.
- Counter width = $clog2(DWELL+1); DWELL=1 means exactly one SHOW cycle.
- led always zero or exactly one-hot; never multiple bits.

## Timing
- Reset (async assert): state IDLE, led=8'h00, hex0=7'h7F, counter=0, in_ready=1, busy=0. Reset mid-SHOW aborts immediately to these values.
- led/hex0 registered, updated at the accepting edge E0; visible in the cycle after E0.
- SHOW occupies DWELL cycles; leaves SHOW at edge E0+DWELL.
- Without macro: in_ready high again from edge E0+DWELL; minimum accept period DWELL+1 cycles... back-to-back next accept at edge E0+DWELL+1.
- With macro: BLANK for one cycle after SHOW, in_ready high from E0+DWELL+1, next accept at E0+DWELL+2.
- in_ready and busy are decoded from state register (no comb path from in_valid).

## Configuration
- DEC38_BLANK_EN defined: on leaving SHOW, led←8'h00 and hex0←7'h7F at the same edge; one BLANK cycle precedes IDLE; display stays blank in IDLE.
- Undefined: no BLANK state; led/hex0 hold last decoded value through IDLE until the next accept.

## Structure
- Shared package: state enum (IDLE/SHOW/BLANK), SEG_BLANK=7'h7F, 8-entry digit pattern constant.
- One sub-module: dec38 (pure combinational 3-to-8 one-hot decoder with enable = in_flag); FSM, counter and segment lookup live in dec38_display.

## Test plan
- Reset: rst_n=0 mid-cycle -> led=8'h00, hex0=7'h7F, in_ready=1 without waiting for a clock edge.
- DWELL=4, accept idx=5 flag=1 -> led=8'h20, hex0=7'h12 for 4 cycles, in_ready=0 for those 4 cycles, then in_ready=1.
- Accept idx=3 flag=0 -> led=8'h00, hex0=7'h7F, busy=1 for DWELL cycles.
- in_valid held high with idx stream 0,7,2 -> each accepted exactly DWELL+1 (no macro) / DWELL+2 (macro) cycles apart; led=8'h01, 8'h80, 8'h04 in order.
- Change in_idx from 1 to 6 while in SHOW -> led stays 8'h02; 6 accepted only after return to IDLE.
- DWELL=1 with DEC38_BLANK_EN: accept idx=4 -> led=8'h10 one cycle, then led=8'h00/hex0=7'h7F, in_ready=1 two cycles after accept.

Source files
------------

// File: rtl/dec38_display_pkg.sv
// Shared types and constants for the dec38_display block.
// Optional feature macro: DEC38_BLANK_EN (adds a one-cycle BLANK state after SHOW).
package dec38_display_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned LED_W = 8;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;

  // All segments off (active-low).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Digit patterns {g,f,e,d,c,b,a}, active-low; entry i is digit i.
  localparam logic [LED_W-1:0][SEG_W-1:0] DIGIT_PAT = {
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/dec38_display_dec38.sv
// Combinational 3-to-8 one-hot decoder; all-zero output when disabled.
module dec38
  import dec38_display_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [LED_W-1:0] onehot_o
);

  // At most one bit set, and only when enabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/dec38_display.sv
// Registered 3-to-8 decoder and seven-segment driver with a programmable dwell.
// Optional feature macro: DEC38_BLANK_EN (blank display for one cycle after SHOW,
// display stays blank in IDLE). Without it, the last value holds through IDLE.
module dec38_display
  import dec38_display_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_flag,
  output logic [LED_W-1:0] led,
  output logic [SEG_W-1:0] hex0,
  output logic             busy
);

  localparam int unsigned CW = $clog2(DWELL + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [SEG_W-1:0] hex_q, hex_d;
  logic [LED_W-1:0] dec_led;

  dec38 u_dec38 (
    .idx_i    (in_idx),
    .en_i     (in_flag),
    .onehot_o (dec_led)
  );

  // State, dwell counter and display registers; reset aborts any SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= '0;
      hex_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      hex_q   <= hex_d;
    end
  end

  // Next state: accept in IDLE, count down the dwell in SHOW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHOW;
          cnt_d   = CW'(DWELL - 1);
          led_d   = dec_led;
          hex_d   = in_flag ? DIGIT_PAT[in_idx] : SEG_BLANK;
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
`ifdef DEC38_BLANK_EN
          state_d = BLANK;
          led_d   = '0;
          hex_d   = SEG_BLANK;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BLANK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status decoded from the state register only.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    led      = led_q;
    hex0     = hex_q;
  end

endmodule

// File: tb/tb_dec38_display.sv
// Directed self-checking bench for dec38_display (DWELL=4 and DWELL=1 instances).
module tb_dec38_display;

  localparam int DW0 = 4;
  localparam int DW1 = 1;
`ifdef DEC38_BLANK_EN
  localparam int BLANK_CYC = 1;
`else
  localparam int BLANK_CYC = 0;
`endif
  localparam int GAP = DW0 + 1 + BLANK_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_flag, in_ready, busy;
  logic [2:0] in_idx;
  logic [7:0] led;
  logic [6:0] hex0;

  logic       v1, flag1, rdy1, busy1;
  logic [2:0] idx1;
  logic [7:0] led1;
  logic [6:0] hex1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dec38_display #(.DWELL(DW0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_flag(in_flag), .led(led), .hex0(hex0), .busy(busy)
  );

  dec38_display #(.DWELL(DW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_idx(idx1), .in_flag(flag1), .led(led1), .hex0(hex1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] idx, input logic flag);
    in_valid = 1'b1;
    in_idx   = idx;
    in_flag  = flag;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_flag = 1'b0;
    v1 = 1'b0; idx1 = '0; flag1 = 1'b0;
    repeat (3) step();
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h exp 00", led); end
    checks++; if (hex0 !== 7'h7F) begin errors++; $display("FAIL reset_hex: got %h exp 7f", hex0); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_rdy_busy: got %b%b exp 10", in_ready, busy); end
    rst_n = 1'b1;
    step();
    accept(3'd2, 1'b1);
    checks++; if (led !== 8'h04) begin errors++; $display("FAIL pre_abort_led: got %h exp 04", led); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL abort_led: got %h exp 00", led); end
    checks++; if (hex0 !== 7'h7F) begin errors++; $display("FAIL abort_hex: got %h exp 7f", hex0); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_rdy_busy: got %b%b exp 10", in_ready, busy); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_show();
    accept(3'd5, 1'b1);
    for (int i = 0; i < DW0; i++) begin
      checks++; if (led !== 8'h20) begin errors++; $display("FAIL show_led[%0d]: got %h exp 20", i, led); end
      checks++; if (hex0 !== 7'h12) begin errors++; $display("FAIL show_hex[%0d]: got %h exp 12", i, hex0); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL show_rdy_busy[%0d]: got %b%b exp 01", i, in_ready, busy); end
      step();
    end
`ifdef DEC38_BLANK_EN
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL blank_rdy_busy: got %b%b exp 01", in_ready, busy); end
    checks++; if (led !== 8'h00 || hex0 !== 7'h7F) begin errors++; $display("FAIL blank_disp: got %h/%h exp 00/7f", led, hex0); end
    step();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL after_show_rdy_busy: got %b%b exp 10", in_ready, busy); end
    checks++; if (led !== 8'h00 || hex0 !== 7'h7F) begin errors++; $display("FAIL idle_disp: got %h/%h exp 00/7f", led, hex0); end
`else
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL after_show_rdy_busy: got %b%b exp 10", in_ready, busy); end
    checks++; if (led !== 8'h20 || hex0 !== 7'h12) begin errors++; $display("FAIL idle_hold: got %h/%h exp 20/12", led, hex0); end
`endif
  endtask

  task automatic test_noflag();
    wait_idle();
    accept(3'd3, 1'b0);
    for (int i = 0; i < DW0; i++) begin
      checks++; if (led !== 8'h00 || hex0 !== 7'h7F) begin errors++; $display("FAIL noflag_disp[%0d]: got %h/%h exp 00/7f", i, led, hex0); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL noflag_busy[%0d]: got %b exp 1", i, busy); end
      step();
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [3];
    logic [7:0] exp_led [3];
    int acc [3];
    logic rd;
    int n;
    seq = '{3'd0, 3'd7, 3'd2};
    exp_led = '{8'h01, 8'h80, 8'h04};
    wait_idle();
    in_valid = 1'b1;
    in_flag  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_idx = seq[k];
      n = 0;
      do begin
        rd = in_ready;
        step();
        n++;
      end while (!rd && n < 20);
      acc[k] = cyc;
      checks++; if (rd !== 1'b1) begin errors++; $display("FAIL b2b_timeout[%0d]: waited %0d cycles", k, n); end
      checks++; if (led !== exp_led[k]) begin errors++; $display("FAIL b2b_led[%0d]: got %h exp %h", k, led, exp_led[k]); end
      if (k > 0) begin
        checks++;
        if (acc[k] - acc[k-1] !== GAP) begin
          errors++; $display("FAIL b2b_gap[%0d]: got %0d exp %0d", k, acc[k] - acc[k-1], GAP);
        end
      end
    end
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_hold();
    int e0;
    int n;
    logic rd;
    wait_idle();
    in_valid = 1'b1;
    in_idx   = 3'd1;
    in_flag  = 1'b1;
    step();
    e0 = cyc;
    in_idx = 3'd6;
    for (int i = 0; i < DW0; i++) begin
      checks++; if (led !== 8'h02) begin errors++; $display("FAIL hold_led[%0d]: got %h exp 02", i, led); end
      step();
    end
    n = 0;
    do begin
      rd = in_ready;
      step();
      n++;
    end while (!rd && n < 20);
    in_valid = 1'b0;
    checks++; if (cyc - e0 !== GAP) begin errors++; $display("FAIL hold_gap: got %0d exp %0d", cyc - e0, GAP); end
    checks++; if (led !== 8'h40 || hex0 !== 7'h02) begin errors++; $display("FAIL hold_next: got %h/%h exp 40/02", led, hex0); end
    wait_idle();
  endtask

  task automatic test_dwell1();
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL d1_pre_rdy: got %b exp 1", rdy1); end
    v1 = 1'b1; idx1 = 3'd4; flag1 = 1'b1;
    step();
    v1 = 1'b0;
    checks++; if (led1 !== 8'h10 || hex1 !== 7'h19) begin errors++; $display("FAIL d1_show: got %h/%h exp 10/19", led1, hex1); end
    checks++; if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL d1_show_rdy_busy: got %b%b exp 01", rdy1, busy1); end
    step();
`ifdef DEC38_BLANK_EN
    checks++; if (led1 !== 8'h00 || hex1 !== 7'h7F) begin errors++; $display("FAIL d1_blank: got %h/%h exp 00/7f", led1, hex1); end
    checks++; if (rdy1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL d1_blank_rdy_busy: got %b%b exp 01", rdy1, busy1); end
    step();
    checks++; if (rdy1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL d1_idle_rdy_busy: got %b%b exp 10", rdy1, busy1); end
    checks++; if (led1 !== 8'h00 || hex1 !== 7'h7F) begin errors++; $display("FAIL d1_idle_disp: got %h/%h exp 00/7f", led1, hex1); end
`else
    checks++; if (rdy1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL d1_idle_rdy_busy: got %b%b exp 10", rdy1, busy1); end
    checks++; if (led1 !== 8'h10 || hex1 !== 7'h19) begin errors++; $display("FAIL d1_idle_hold: got %h/%h exp 10/19", led1, hex1); end
    step();
    checks++; if (rdy1 !== 1'b1 || led1 !== 8'h10) begin errors++; $display("FAIL d1_idle2: got rdy=%b led=%h exp 1/10", rdy1, led1); end
`endif
  endtask

  initial begin
    test_reset();
    test_show();
    test_noflag();
    test_back_to_back();
    test_hold();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
